// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: datapath widths and the data-memory boot controller state encoding.
package rv32i_pkg;

  localparam int unsigned DPW = 32;
  localparam int unsigned ADW = 32;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } dmem_state_e;

endpackage

// File: rtl/dmem_arb.sv
// Data-memory port arbiter: core-priority grant in RUN with a host starvation guard,
// host-owned port in LOAD/HALT, and the combinational mem_* mux.
module dmem_arb #(
  parameter int unsigned DPW        = 32,
  parameter int unsigned ADW        = 32,
  parameter int unsigned STARVE_LIM = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  rv32i_pkg::dmem_state_e   state,
  input  logic                     host_valid,
  input  logic                     host_we,
  input  logic                     host_bad,
  input  logic [ADW-1:0]           host_addr,
  input  logic [DPW-1:0]           host_wdata,
  input  logic                     core_req,
  input  logic                     core_we,
  input  logic [ADW-1:0]           core_addr,
  input  logic [DPW-1:0]           core_wdata,
  output logic                     host_gnt,
  output logic                     starve_gnt,
  output logic                     mem_en,
  output logic                     mem_we,
  output logic [ADW-1:0]           mem_addr,
  output logic [DPW-1:0]           mem_wdata
);
  import rv32i_pkg::*;

  localparam int unsigned CntW = $clog2(STARVE_LIM + 1);
  localparam logic [CntW-1:0] Lim = CntW'(STARVE_LIM);
  localparam logic [ADW-1:0] WordMask = ~ADW'(3);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            core_gnt;
  logic            starved;

  assign starved = (cnt_q == Lim);

  always_comb begin
    host_gnt   = 1'b0;
    core_gnt   = 1'b0;
    starve_gnt = 1'b0;
    if (!rst) begin
      case (state)
        LOAD, HALT: host_gnt = 1'b1;
        RUN: begin
          if (!core_req) begin
            host_gnt = 1'b1;
          end else if (starved) begin
            host_gnt   = 1'b1;
            starve_gnt = 1'b1;
          end else begin
            core_gnt = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Counts consecutive denied host cycles; only meaningful inside RUN.
  always_comb begin
    cnt_d = cnt_q;
    if (state != RUN || host_gnt || !host_valid) begin
      cnt_d = '0;
    end else if (!starved) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (host_gnt && host_valid && !host_bad) begin
      mem_en    = 1'b1;
      mem_we    = host_we;
      mem_addr  = host_addr & WordMask;
      mem_wdata = host_wdata;
    end else if (core_gnt) begin
      mem_en    = 1'b1;
      mem_we    = core_we;
      mem_addr  = core_addr & WordMask;
      mem_wdata = core_wdata;
    end
  end

endmodule

// File: rtl/dmem_boot_ctrl.sv
// Boot/access controller for the RV32I data memory: holds the core in reset during host preload,
// then shares the port. Optional sticky misalignment error enabled by DMEM_BOOT_CTRL_ERR_EN.
module dmem_boot_ctrl #(
  parameter int unsigned DPW        = rv32i_pkg::DPW,
  parameter int unsigned ADW        = rv32i_pkg::ADW,
  parameter int unsigned STARVE_LIM = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           host_valid,
  output logic           host_ready,
  input  logic           host_we,
  input  logic [ADW-1:0] host_addr,
  input  logic [DPW-1:0] host_wdata,
  output logic [DPW-1:0] host_rdata,
  output logic           host_rvalid,
  input  logic           host_go,
  input  logic           host_halt,
  output logic           core_rst,
  input  logic           core_req,
  input  logic           core_we,
  input  logic [ADW-1:0] core_addr,
  input  logic [DPW-1:0] core_wdata,
  output logic [DPW-1:0] core_rdata,
  output logic           core_stall,
  output logic           mem_en,
  output logic           mem_we,
  output logic [ADW-1:0] mem_addr,
  output logic [DPW-1:0] mem_wdata,
  input  logic [DPW-1:0] mem_rdata,
  output logic [1:0]     state
`ifdef DMEM_BOOT_CTRL_ERR_EN
  ,
  output logic           err
`endif
);
  import rv32i_pkg::*;

  dmem_state_e state_q, state_d;
  logic        host_gnt;
  logic        starve_gnt;
  logic        host_bad;
  logic        host_acc;
  logic        rvalid_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      LOAD:    if (host_go) state_d = RUN;
      RUN:     if (host_halt) state_d = HALT;
      HALT:    if (host_go && !host_halt) state_d = RUN;
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LOAD;
    end else begin
      state_q <= state_d;
    end
  end

`ifdef DMEM_BOOT_CTRL_ERR_EN
  logic err_q;

  assign host_bad = (host_addr[1:0] != 2'b00);

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (host_acc && host_bad) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign host_bad = 1'b0;
`endif

  dmem_arb #(
    .DPW        (DPW),
    .ADW        (ADW),
    .STARVE_LIM (STARVE_LIM)
  ) u_arb (
    .clk        (clk),
    .rst        (rst),
    .state      (state_q),
    .host_valid (host_valid),
    .host_we    (host_we),
    .host_bad   (host_bad),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .core_req   (core_req),
    .core_we    (core_we),
    .core_addr  (core_addr),
    .core_wdata (core_wdata),
    .host_gnt   (host_gnt),
    .starve_gnt (starve_gnt),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata)
  );

  assign host_ready = host_gnt;
  assign host_acc   = host_valid && host_gnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid_q <= 1'b0;
    end else begin
      rvalid_q <= host_acc && !host_we && !host_bad;
    end
  end

  // Gating with rst drops a read response that is in flight when reset arrives.
  assign host_rvalid = rvalid_q && !rst;
  assign host_rdata  = host_rvalid ? mem_rdata : '0;
  assign core_rdata  = mem_rdata;

  assign core_rst   = rst || (state_q == LOAD);
  assign core_stall = !rst && ((state_q == HALT) || starve_gnt);
  assign state      = state_q;

endmodule

// File: tb/tb_dmem_boot_ctrl.sv
// Scoreboard bench for dmem_boot_ctrl: host read responses are queued at issue and checked by a
// separate monitor; grants and mem_* are checked against a word-array reference model.
module tb_dmem_boot_ctrl;

  localparam int unsigned LIM = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        host_valid, host_we, host_go, host_halt;
  logic        host_ready, host_rvalid;
  logic [31:0] host_addr, host_wdata, host_rdata;
  logic        core_rst, core_req, core_we, core_stall;
  logic [31:0] core_addr, core_wdata, core_rdata;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [1:0]  state;
`ifdef DMEM_BOOT_CTRL_ERR_EN
  logic        err;
`endif

  dmem_boot_ctrl #(
    .DPW        (32),
    .ADW        (32),
    .STARVE_LIM (LIM)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .host_valid  (host_valid),
    .host_ready  (host_ready),
    .host_we     (host_we),
    .host_addr   (host_addr),
    .host_wdata  (host_wdata),
    .host_rdata  (host_rdata),
    .host_rvalid (host_rvalid),
    .host_go     (host_go),
    .host_halt   (host_halt),
    .core_rst    (core_rst),
    .core_req    (core_req),
    .core_we     (core_we),
    .core_addr   (core_addr),
    .core_wdata  (core_wdata),
    .core_rdata  (core_rdata),
    .core_stall  (core_stall),
    .mem_en      (mem_en),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .state       (state)
`ifdef DMEM_BOOT_CTRL_ERR_EN
    ,
    .err         (err)
`endif
  );

  always #5 clk = ~clk;

  // Data memory attached to the port: write on the edge, read data one cycle later.
  logic [31:0] ram [0:63];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr[7:2]] <= mem_wdata;
      else        mem_rdata <= ram[mem_addr[7:2]];
    end
  end

  logic [31:0] model [0:63];
  logic [31:0] exp_q [$];
  int          wait_cnt;
  int          vectors;
  int          miscompares;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: every presented host response must match the oldest queued expectation.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (host_rvalid) begin
        if (exp_q.size() == 0) check("unexpected_rvalid", 32'(host_rvalid), 32'd0);
        else check("host_rdata", host_rdata, exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic logic [7:0] rnd_addr();
    logic [5:0] w = 6'($urandom_range(4, 63));
`ifdef DMEM_BOOT_CTRL_ERR_EN
    return {w, 2'b00};
`else
    return {w, 2'($urandom)};
`endif
  endfunction

  // Host transfer in LOAD (st=0) or HALT (st=2), where the host always owns the port.
  task automatic host_op(input bit we, input logic [7:0] a, input logic [31:0] d,
                         input int st, input bit expect_rv);
    host_valid = 1'b1; host_we = we; host_addr = {24'h0, a}; host_wdata = d;
    core_req = 1'($urandom); core_we = 1'b1; core_addr = 32'($urandom); core_wdata = $urandom;
    #1;
    check("own_state", 32'(state), 32'(st));
    check("own_core_rst", 32'(core_rst), 32'(st == 0));
    check("own_core_stall", 32'(core_stall), 32'(st == 2));
    check("own_host_ready", 32'(host_ready), 32'd1);
    check("own_mem_en", 32'(mem_en), 32'd1);
    check("own_mem_we", 32'(mem_we), 32'(we));
    check("own_mem_addr", mem_addr, {24'h0, a[7:2], 2'b00});
    if (we) begin
      check("own_mem_wdata", mem_wdata, d);
      model[a[7:2]] = d;
    end else if (expect_rv) begin
      exp_q.push_back(model[a[7:2]]);
    end
    @(negedge clk);
    host_valid = 1'b0; core_req = 1'b0;
  endtask

  task automatic ctl(input bit go, input bit halt);
    host_valid = 1'b0; core_req = 1'b0; host_go = go; host_halt = halt;
    @(negedge clk);
    host_go = 1'b0; host_halt = 1'b0;
    wait_cnt = 0;
  endtask

  // One RUN cycle; grant predicted from the wait count of the reference model.
  task automatic run_cycle(input bit cr, input bit cw, input logic [7:0] ca, input logic [31:0] cd,
                           input bit hv, input bit hw, input logic [7:0] ha,
                           input logic [31:0] hd);
    bit          hg, cg, cload;
    logic [31:0] cexp;
    core_req = cr; core_we = cw; core_addr = {24'h0, ca}; core_wdata = cd;
    host_valid = hv; host_we = hw; host_addr = {24'h0, ha}; host_wdata = hd;
    hg = !cr || (wait_cnt == int'(LIM));
    cg = cr && !hg;
    cload = 1'b0;
    cexp = '0;
    #1;
    check("run_state", 32'(state), 32'd1);
    check("run_core_rst", 32'(core_rst), 32'd0);
    check("run_host_ready", 32'(host_ready), 32'(hg));
    check("run_core_stall", 32'(core_stall), 32'(cr && hg));
    check("run_mem_en", 32'(mem_en), 32'((hg && hv) || cg));
    if (hg && hv) begin
      check("run_mem_addr_h", mem_addr, {24'h0, ha[7:2], 2'b00});
      check("run_mem_we_h", 32'(mem_we), 32'(hw));
      if (hw) begin
        check("run_mem_wdata_h", mem_wdata, hd);
        model[ha[7:2]] = hd;
      end else begin
        exp_q.push_back(model[ha[7:2]]);
      end
    end else if (cg) begin
      check("run_mem_addr_c", mem_addr, {24'h0, ca[7:2], 2'b00});
      check("run_mem_we_c", 32'(mem_we), 32'(cw));
      if (cw) begin
        check("run_mem_wdata_c", mem_wdata, cd);
        model[ca[7:2]] = cd;
      end else begin
        cload = 1'b1;
        cexp = model[ca[7:2]];
      end
    end
    if (hg || !hv) wait_cnt = 0;
    else if (wait_cnt < int'(LIM)) wait_cnt++;
    @(posedge clk);
    #1;
    if (cload) check("core_rdata", core_rdata, cexp);
    @(negedge clk);
  endtask

  task automatic run_random(input int n);
    for (int i = 0; i < n; i++) begin
      run_cycle(($urandom_range(0, 9) < 8), 1'($urandom), rnd_addr(), $urandom,
                ($urandom_range(0, 9) < 7), 1'($urandom), rnd_addr(), $urandom);
    end
  endtask

  initial begin
    vectors = 0; miscompares = 0; wait_cnt = 0;
    for (int i = 0; i < 64; i++) begin
      ram[i] = '0;
      model[i] = '0;
    end
    mem_rdata = '0;
    host_go = 0; host_halt = 0; host_we = 0; host_addr = '0; host_wdata = '0;
    core_we = 1; core_addr = 32'h20; core_wdata = 32'h1;
    // Requests held high during reset must not be granted.
    rst = 1; host_valid = 1; core_req = 1;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("rst_host_ready", 32'(host_ready), 32'd0);
    check("rst_mem_en", 32'(mem_en), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_core_rst", 32'(core_rst), 32'd1);
    check("rst_core_stall", 32'(core_stall), 32'd0);
    check("rst_host_rvalid", 32'(host_rvalid), 32'd0);
    check("rst_state", 32'(state), 32'd0);
    @(negedge clk);
    rst = 0; host_valid = 0; core_req = 0;

    // Preload, then read back word 0x4.
    host_op(1, 8'h00, 32'h5, 0, 1);
    host_op(1, 8'h04, 32'h8, 0, 1);
    host_op(0, 8'h04, 32'h0, 0, 1);
    #1;
    check("preload_rvalid", 32'(host_rvalid), 32'd1);
    check("preload_rdata", host_rdata, 32'h8);
    check("preload_core_rst", 32'(core_rst), 32'd1);
    for (int i = 0; i < 20; i++) host_op(1'($urandom), rnd_addr(), $urandom, 0, 1);

    // Boot: RUN and core out of reset on the cycle after host_go.
    ctl(1, 0);
    run_cycle(1, 1, 8'h08, 32'hD, 0, 0, 8'h00, 32'h0);

    // Starvation: host granted on exactly every (LIM+1)th cycle.
    run_cycle(0, 0, 8'h00, 32'h0, 0, 0, 8'h00, 32'h0);
    for (int i = 1; i <= 2 * int'(LIM + 1); i++) begin
      core_req = 1;
      run_cycle(1, 0, 8'h08, 32'h0, 1, 0, 8'h04, 32'h0);
      check("starve_cycle", 32'(exp_q.size() > 0 && host_rvalid), 32'(i % int'(LIM + 1) == 0));
    end
    run_random(300);

    // Halt wins over go; HALT holds the core stalled while the host reads.
    ctl(1, 1);
    host_op(0, 8'h00, 32'h0, 2, 1);
    check("halt_read_model", model[0], 32'h5);
    for (int i = 0; i < 10; i++) host_op(1'($urandom), rnd_addr(), $urandom, 2, 1);
    ctl(1, 0);
    run_random(150);

    // Reset the cycle after an accepted host read: no response, back to LOAD.
    ctl(0, 1);
    host_op(0, 8'h10, 32'h0, 2, 0);
    rst = 1;
    #1;
    check("rstmid_rvalid", 32'(host_rvalid), 32'd0);
    check("rstmid_core_rst", 32'(core_rst), 32'd1);
    check("rstmid_core_stall", 32'(core_stall), 32'd0);
    @(negedge clk);
    rst = 0;
    wait_cnt = 0;
    #1;
    check("rstmid_state", 32'(state), 32'd0);
    check("rstmid_rvalid2", 32'(host_rvalid), 32'd0);
    check("rstmid_core_rst2", 32'(core_rst), 32'd1);
    @(negedge clk);

`ifdef DMEM_BOOT_CTRL_ERR_EN
    host_valid = 1; host_we = 1; host_addr = 32'h6; host_wdata = 32'hBAD;
    #1;
    check("err_host_ready", 32'(host_ready), 32'd1);
    check("err_mem_en", 32'(mem_en), 32'd0);
    check("err_before", 32'(err), 32'd0);
    @(negedge clk);
    host_valid = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("err_sticky", 32'(err), 32'd1);
      @(negedge clk);
    end
    rst = 1;
    @(negedge clk);
    rst = 0;
    #1;
    check("err_cleared", 32'(err), 32'd0);
    @(negedge clk);
`endif

    @(negedge clk);
    @(negedge clk);
    check("pending_responses", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dmem_boot_ctrl.md
# dmem_boot_ctrl

Boot and access controller for the RV32I core's data memory port. It holds the core in reset while a host preloads data memory. It then releases the core and shares the single data-memory port between the core's MEM stage and the host, using priority arbitration with a starvation guard. It sits between `top`'s MEM stage, the data memory, and the external load/debug interface.

## Interface
- `DPW`, default `rv32i_pkg::DPW` (32): data width.
- `ADW`, default `rv32i_pkg::ADW` (32): address width.
- `STARVE_LIM`, default 8: consecutive denied host cycles in RUN before the host is forced a grant; legal range 1..255.

Ports:
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `host_valid`  in  1  host request.
- `host_ready`  out  1  host request accepted this cycle.
- `host_we`  in  1  host write (1) / read (0).
- `host_addr`  in  ADW  host byte address.
- `host_wdata`  in  DPW  host write data.
- `host_rdata`  out  DPW  host read data.
- `host_rvalid`  out  1  `host_rdata` valid.
- `host_go`  in  1  enter or resume RUN.
- `host_halt`  in  1  enter HALT.
- `core_rst`  out  1  reset to core pipeline.
- `core_req`  in  1  MEM-stage load/store.
- `core_we`  in  1  MEM-stage store (`memwriteM`).
- `core_addr`  in  ADW  `aluresultM`.
- `core_wdata`  in  DPW  `Rd2M`.
- `core_rdata`  out  DPW  load data.
- `core_stall`  out  1  freeze core pipeline.
- `mem_en`  out  1  memory access strobe.
- `mem_we`  out  1  memory write strobe.
- `mem_addr`  out  ADW  memory address.
- `mem_wdata`  out  DPW  memory write data.
- `mem_rdata`  in  DPW  memory read data, valid 1 cycle after a read.
- `state`  out  2  FSM state: LOAD=0, RUN=1, HALT=2.

## Operation
- The FSM has three states.
  - LOAD: the state on reset. `core_rst`=1. Host owns the port. `core_req` is ignored. `host_go` moves to RUN.
  - RUN: `core_rst`=0. The core has priority. `host_halt` moves to HALT.
  - HALT: `core_rst`=0 and `core_stall`=1 continuously. Host owns the port. `host_go` moves to RUN.
- `host_go` and `host_halt` together: halt wins (from LOAD, go wins, because halt is ignored in LOAD).
- Grant in LOAD/HALT: `host_ready`=`host_valid`-independent 1; a transfer occurs when `host_valid` is high.
- Grant in RUN:
  - If `core_req`=0, the host is granted.
  - If `core_req`=1, the core is granted, unless the starvation counter equals `STARVE_LIM`.
  - In that case the host is granted, `core_stall`=1 for that cycle, and the counter clears.
- Starvation counter:
  - Increments on each RUN cycle with `host_valid`=1 and no host grant.
  - Clears on any host grant, when `host_valid`=0, and on leaving RUN.
  - Saturates at `STARVE_LIM`.
- Port mux is combinational: `mem_*` carries the granted requester's signals. `mem_en`=0 when nobody is granted.
- Address handling: word access only; `mem_addr` = requester address with bits [1:0] forced to 0.
- Read return:
  - `host_rvalid` is a register, set the cycle after an accepted host read; `host_rdata` = `mem_rdata` while `host_rvalid`.
  - `core_rdata` = `mem_rdata` directly; the core sees load data one cycle after its grant.

## Timing
- Reset values: `state`=LOAD, `core_rst`=1, `core_stall`=0, `host_ready`=0, `host_rvalid`=0, `mem_en`=0, `mem_we`=0, counter=0. During `rst`=1, all grants are forced to 0.
- The FSM transition takes effect the cycle after `host_go`/`host_halt`; `core_rst` drops in the first RUN cycle.
- Host write latency is 0: memory is written on the accepting edge. Host read latency is 1 cycle.
- Worst-case host wait in RUN is `STARVE_LIM`+1 cycles.
- Reset mid-read suppresses the pending `host_rvalid`. Reset in RUN/HALT returns to LOAD with `core_rst`=1 in the same cycle as `rst`.

## Configuration
- `DMEM_BOOT_CTRL_ERR_EN` defined:
  - Adds output `err` (1 bit) and a sticky register, cleared only by `rst`.
  - A host request with `host_addr[1:0]`≠0 is still accepted (`host_ready`=1). It performs no memory access, produces no `host_rvalid`, and sets `err` the next cycle.
- Undefined: no `err` port; `host_addr[1:0]` is ignored.

## Structure
- `rv32i_pkg` gains a `dmem_state_e` enum (LOAD, RUN, HALT; 2 bits).
- `STARVE_LIM` and the counter width are computed locally.
- One sub-module, `dmem_arb`: the combinational grant/mux plus the starvation counter. The FSM and read-return logic live in the top `dmem_boot_ctrl`.

## Test plan
- Preload: in LOAD, host writes 0x5 @0x0 and 0x8 @0x4, then reads 0x4.
  - `host_rvalid` one cycle after the read with `host_rdata`=0x8.
  - `core_rst`=1 throughout.
- Boot: `host_go` pulse.
  - `state`=RUN and `core_rst`=0 on the next cycle.
  - A core store of 0xD to 0x8 appears on `mem_*` the same cycle.
- Starvation: `STARVE_LIM`=8, `core_req` held 1, `host_valid` held 1.
  - Host granted and `core_stall`=1 exactly on the 9th cycle, then the core resumes.
- Halt/resume: `host_halt` and `host_go` asserted together in RUN go to HALT (`core_stall`=1). Host reads 0x0 and gets 0x5. `host_go` returns to RUN.
- Reset mid-read: `rst` in the cycle after a host read is accepted.
  - `host_rvalid` stays 0.
  - `state`=LOAD, `core_rst`=1.
- With `DMEM_BOOT_CTRL_ERR_EN`: host write to 0x6.
  - `mem_en`=0.
  - `err`=1 the next cycle and it stays 1 until `rst`.
